// File: rtl/register_bus_master.sv
// Serial-command register bus master: decodes write (0x57, addr, data) and read (0x52, addr)
// byte commands, runs one register bus cycle and returns an ACK or read-data byte.
module register_bus_master #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_busy,
  output logic                  o_wr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_busy,
  output logic [7:0]            o_err_cnt
);

  localparam logic [7:0]      CmdWrite = 8'h57;
  localparam logic [7:0]      CmdRead  = 8'h52;
  localparam logic [7:0]      AckByte  = 8'h06;
  localparam int unsigned     TmoW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      LatLast  = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StBusWr, StBusRd, StRdWait, StTxReq
  } state_e;

  state_e                  state_q, state_d;
  logic                    cmd_wr_q, cmd_wr_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [1:0]              lat_q, lat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    wr_q, wr_d;
  logic                    busy_q, busy_d;
  logic [7:0]              err_q, err_d;
  logic                    err_inc;

  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    tmo_d      = tmo_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    wr_d       = 1'b0;
    err_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_rx_valid) begin
          if (i_rx_data == CmdWrite || i_rx_data == CmdRead) begin
            cmd_wr_d = (i_rx_data == CmdWrite);
            tmo_d    = '0;
            state_d  = StGetAddr;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      StGetAddr: begin
        if (i_rx_valid) begin
          addr_d  = ADDR_WIDTH'(i_rx_data);
          tmo_d   = '0;
          state_d = cmd_wr_q ? StGetData : StBusRd;
        end else if (tmo_q == TmoLast) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StGetData: begin
        if (i_rx_valid) begin
          wdata_d = DATA_WIDTH'(i_rx_data);
          tmo_d   = '0;
          wr_d    = 1'b1;  // registered, so the strobe lines up with the BUS_WR cycle
          state_d = StBusWr;
        end else if (tmo_q == TmoLast) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StBusWr: begin
        err_inc   = i_rx_valid;
        tx_data_d = AckByte;
        state_d   = StTxReq;
      end
      StBusRd: begin
        err_inc = i_rx_valid;
        lat_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        err_inc = i_rx_valid;
        if (lat_q == LatLast) begin
          tx_data_d = 8'(i_rdata);
          state_d   = StTxReq;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StTxReq: begin
        err_inc = i_rx_valid;
        if (!i_tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cmd_wr_q   <= 1'b0;
      tmo_q      <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_wr_q   <= cmd_wr_d;
      tmo_q      <= tmo_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_wr       = wr_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_busy     = busy_q;
  assign o_err_cnt  = err_q;

endmodule

// File: doc/register_bus_master.md
REGISTER_BUS_MASTER -- requirements
Module: register_bus_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: register bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: register bus data width and serial byte width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: the maximum number of idle cycles allowed between bytes of one command.
REQ-004 SHALL have parameter RD_LATENCY, default 1, legal range 1-4: the number of cycles from the read address being driven to valid read data.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_rx_data, input, 8 bits: byte from the serial receiver.
REQ-008 SHALL have port i_rx_valid, input, 1 bit: one-cycle strobe qualifying i_rx_data.
REQ-009 SHALL have port o_tx_data, output, 8 bits: response byte to the serial transmitter.
REQ-010 SHALL have port o_tx_start, output, 1 bit: one-cycle strobe launching o_tx_data.
REQ-011 SHALL have port i_tx_busy, input, 1 bit: the transmitter is sending.
REQ-012 SHALL have port o_wr, output, 1 bit: register bus write strobe.
REQ-013 SHALL have port o_addr, output, ADDR_WIDTH bits: register bus address.
REQ-014 SHALL have port o_wdata, output, DATA_WIDTH bits: register bus write data.
REQ-015 SHALL have port i_rdata, input, DATA_WIDTH bits: OR of all register block read outputs; unaddressed blocks drive 0.
REQ-016 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 SHALL have port o_err_cnt, output, 8 bits: count of protocol errors; saturates at 0xFF.

Function
REQ-018 SHALL accept two command formats: write = 0x57, addr, data; read = 0x52, addr.
REQ-019 SHALL use the states IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, TX_REQ.
REQ-020 SHALL, in IDLE, go to GET_ADDR when i_rx_valid=1 and i_rx_data is 0x57 or 0x52, and latch the command type.
REQ-021 SHALL, on any other byte received in IDLE, discard it, increment o_err_cnt, and stay in IDLE.
REQ-022 SHALL, in GET_ADDR on i_rx_valid, latch o_addr and go to GET_DATA for a write or BUS_RD for a read.
REQ-023 SHALL, in GET_DATA on i_rx_valid, latch o_wdata and go to BUS_WR.
REQ-024 SHALL, in BUS_WR, assert o_wr=1 for exactly one cycle with o_addr/o_wdata stable, load o_tx_data=0x06 (ACK), and go to TX_REQ.
REQ-025 SHALL, in BUS_RD, keep o_wr=0 and o_addr stable, then spend RD_LATENCY cycles in RD_WAIT.
REQ-026 SHALL, on the last RD_WAIT cycle, capture i_rdata into o_tx_data and go to TX_REQ.
REQ-027 SHALL hold o_wr=0 in every state except BUS_WR.
REQ-028 SHALL hold o_addr and o_wdata at their last latched values outside GET_ADDR and GET_DATA.
REQ-029 SHALL, in TX_REQ, assert o_tx_start for one cycle on the first cycle with i_tx_busy=0, then return to IDLE.
REQ-030 SHALL, while i_tx_busy=1, hold TX_REQ with o_tx_start=0 indefinitely.
REQ-031 SHALL reset the inter-byte timeout counter on every accepted byte and on entry to GET_ADDR.
REQ-032 SHALL, in GET_ADDR and GET_DATA, abort to IDLE and increment o_err_cnt when the timeout counter reaches TIMEOUT_CYCLES with no i_rx_valid; no bus cycle and no response SHALL occur.
REQ-033 SHALL, when i_rx_valid and the timeout coincide in the same cycle, accept the byte and not abort.
REQ-034 SHALL discard any byte received in BUS_WR, BUS_RD, RD_WAIT or TX_REQ, and increment o_err_cnt for it.
REQ-035 SHALL, when two error sources occur in one cycle, increment o_err_cnt by 1 only.
REQ-036 SHALL never wrap o_err_cnt; it stays at 0xFF once reached.

Reset
REQ-037 SHALL, on i_rst=1 at any time (including mid-command), immediately force the state to IDLE and set every output to 0: o_wr, o_addr, o_wdata, o_tx_data, o_tx_start, o_busy, o_err_cnt.
REQ-038 SHALL also clear the timeout counter and the latched command type on reset.
REQ-039 SHALL resume operation on the first rising clock edge after i_rst is deasserted, with no bus strobe issued during or because of reset.

Verification
REQ-040 SHALL pass this scenario: bytes 0x57,0x03,0xA5 -> exactly one cycle with o_wr=1, o_addr=0x03, o_wdata=0xA5, then o_tx_start with o_tx_data=0x06.
REQ-041 SHALL pass this scenario: bytes 0x52,0x03 with the register holding 0xA5 and RD_LATENCY=1 -> o_wr stays 0, i_rdata is sampled 1 cycle after BUS_RD, and the response byte is 0xA5.
REQ-042 SHALL pass this scenario: byte 0x41 in IDLE -> no bus activity, no response, o_err_cnt increments 0->1.
REQ-043 SHALL pass this scenario: 0x57,0x03 followed by a gap of TIMEOUT_CYCLES (use 16 in simulation) -> return to IDLE, o_err_cnt=1, o_wr never asserted.
REQ-044 SHALL pass this scenario: read response pending with i_tx_busy=1 for 20 cycles -> o_tx_start=0 throughout, and exactly one o_tx_start in the cycle after i_tx_busy falls.
REQ-045 SHALL pass this scenario: i_rst pulsed asynchronously between clock edges while in GET_DATA -> all outputs 0 immediately, and the following 0x57,0x05,0x11 sequence completes normally.
